// File: rtl/edge_pkg.sv
// Shared types and constants for the edge frame writer: FSM state encoding
// and the pixel values used for border and binarised output.
package edge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SKIP,
    ST_STREAM,
    ST_FLUSH,
    ST_DONE
  } ewr_state_t;

  localparam logic [3:0] EDGE_BORDER_VAL = 4'h0;
  localparam logic [3:0] EDGE_MAX_VAL    = 4'hF;

endpackage

// File: rtl/edge_xy_counter.sv
// Raster position counter: walks x/y and the linear address one pixel per
// enable, and flags border pixels and the final pixel of the frame.
module edge_xy_counter #(
  parameter int IMG_W  = 638,
  parameter int IMG_H  = 478,
  parameter int ADDR_W = $clog2(IMG_W*IMG_H),
  parameter int XW     = $clog2(IMG_W),
  parameter int YW     = $clog2(IMG_H)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clear,
  input  logic              i_enable,
  output logic [XW-1:0]     o_x,
  output logic [YW-1:0]     o_y,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_border,
  output logic              o_last
);

  localparam logic [XW-1:0]     X_LAST = XW'(IMG_W - 1);
  localparam logic [XW-1:0]     X_BHI  = XW'(IMG_W - 2);
  localparam logic [XW-1:0]     X_BLO  = XW'(2);
  localparam logic [YW-1:0]     Y_LAST = YW'(IMG_H - 1);
  localparam logic [YW-1:0]     Y_BHI  = YW'(IMG_H - 2);
  localparam logic [YW-1:0]     Y_BLO  = YW'(2);
  localparam logic [ADDR_W-1:0] A_LAST = ADDR_W'(IMG_W*IMG_H - 1);

  logic [XW-1:0]     r_x;
  logic [YW-1:0]     r_y;
  logic [ADDR_W-1:0] r_addr;

  // Everything wraps back to the origin after the last pixel so the address never leaves the frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x    <= '0;
      r_y    <= '0;
      r_addr <= '0;
    end else if (i_clear) begin
      r_x    <= '0;
      r_y    <= '0;
      r_addr <= '0;
    end else if (i_enable) begin
      if (r_x == X_LAST) begin
        r_x <= '0;
        r_y <= (r_y == Y_LAST) ? '0 : r_y + 1'b1;
      end else begin
        r_x <= r_x + 1'b1;
      end
      r_addr <= (r_addr == A_LAST) ? '0 : r_addr + 1'b1;
    end
  end

  assign o_x      = r_x;
  assign o_y      = r_y;
  assign o_addr   = r_addr;
  assign o_border = (r_x < X_BLO) || (r_x >= X_BHI) || (r_y < Y_BLO) || (r_y >= Y_BHI);
  assign o_last   = (r_addr == A_LAST);

endmodule

// File: rtl/edge_frame_writer.sv
// Realigns the Sobel edge stream to the image raster and writes every pixel
// of a frame exactly once, zeroing the border and padding the missing tail.
module edge_frame_writer
  import edge_pkg::*;
#(
  parameter int IMG_W  = 638,
  parameter int IMG_H  = 478,
  parameter int SKIP   = 2*IMG_W + 2,
  parameter int ADDR_W = $clog2(IMG_W*IMG_H)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic [3:0]        pixel_in,
  input  logic              in_valid,
  input  logic              thresh_en,
  input  logic [3:0]        threshold,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [3:0]        wr_data,
  output logic              busy,
  output logic              frame_done
);

  localparam int PIX      = IMG_W*IMG_H;
  localparam int STREAM_N = PIX - SKIP;
  localparam int XW       = $clog2(IMG_W);
  localparam int YW       = $clog2(IMG_H);
  localparam int SKW      = $clog2(SKIP + 1);

  localparam logic [SKW-1:0] SKIP_LAST = SKW'(SKIP - 1);
  localparam logic [XW-1:0]  SEND_X    = XW'((STREAM_N - 1) % IMG_W);
  localparam logic [YW-1:0]  SEND_Y    = YW'((STREAM_N - 1) / IMG_W);

  ewr_state_t        r_state;
  ewr_state_t        w_next;
  logic [SKW-1:0]    r_skipCnt;
  logic              w_clear;
  logic              w_advance;
  logic              w_write;
  logic              w_skipInc;
  logic [XW-1:0]     w_x;
  logic [YW-1:0]     w_y;
  logic [ADDR_W-1:0] w_addr;
  logic              w_border;
  logic              w_last;
  logic [3:0]        w_pixData;
  logic              r_wrEn;
  logic [ADDR_W-1:0] r_wrAddr;
  logic [3:0]        r_wrData;
  logic              r_busy;
  logic              r_frameDone;

  edge_xy_counter #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .ADDR_W(ADDR_W),
    .XW    (XW),
    .YW    (YW)
  ) u_xy (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_clear),
    .i_enable(w_advance),
    .o_x     (w_x),
    .o_y     (w_y),
    .o_addr  (w_addr),
    .o_border(w_border),
    .o_last  (w_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // frame_start wins from any state, so a restart always discards the frame in flight.
  always_comb begin
    w_next    = r_state;
    w_clear   = 1'b0;
    w_advance = 1'b0;
    w_write   = 1'b0;
    w_skipInc = 1'b0;
    if (frame_start) begin
      w_next  = ST_SKIP;
      w_clear = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: w_next = ST_IDLE;
        ST_SKIP: begin
          if (in_valid) begin
            w_skipInc = 1'b1;
            if (r_skipCnt == SKIP_LAST) w_next = ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (in_valid) begin
            w_write   = 1'b1;
            w_advance = 1'b1;
            if ((w_x == SEND_X) && (w_y == SEND_Y)) w_next = ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          w_write   = 1'b1;
          w_advance = 1'b1;
          if (w_last) w_next = ST_DONE;
        end
        ST_DONE: w_next = ST_IDLE;
        default: w_next = ST_IDLE;
      endcase
    end
  end

  // The sample arriving with frame_start is already the first warm-up sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_skipCnt <= '0;
    else if (w_clear)   r_skipCnt <= in_valid ? SKW'(1) : '0;
    else if (w_skipInc) r_skipCnt <= r_skipCnt + 1'b1;
  end

  always_comb begin
    w_pixData = EDGE_BORDER_VAL;
    if ((r_state == ST_STREAM) && !w_border) begin
      if (thresh_en) w_pixData = (pixel_in >= threshold) ? EDGE_MAX_VAL : 4'h0;
      else           w_pixData = pixel_in;
    end
  end

  // busy covers the DONE->IDLE step so it drops only after frame_done has been seen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrEn      <= 1'b0;
      r_wrAddr    <= '0;
      r_wrData    <= '0;
      r_busy      <= 1'b0;
      r_frameDone <= 1'b0;
    end else begin
      r_wrEn <= w_write;
      if (w_write) begin
        r_wrAddr <= w_addr;
        r_wrData <= w_pixData;
      end
      r_busy      <= (w_next != ST_IDLE) || (r_state != ST_IDLE);
      r_frameDone <= (r_state == ST_DONE) && !frame_start;
    end
  end

  assign wr_en      = r_wrEn;
  assign wr_addr    = r_wrAddr;
  assign wr_data    = r_wrData;
  assign busy       = r_busy;
  assign frame_done = r_frameDone;

endmodule
